// File: rtl/duty_scaler_seq_pkg.sv
// Shared definitions for the duty_scaler_seq controller: FSM state codes,
// channel count and channel index constants, and the input snapshot type.
package duty_scaler_seq_pkg;

  localparam int NUM_CH = 4;

  // Channel processing order: red, green, blue, white
  localparam logic [1:0] CH_RED   = 2'd0;
  localparam logic [1:0] CH_GREEN = 2'd1;
  localparam logic [1:0] CH_BLUE  = 2'd2;
  localparam logic [1:0] CH_WHITE = 2'd3;

  // FSM state encoding
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_STORE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  typedef logic [2:0] state_t;

  // Inputs frozen at the start of a sequence
  typedef struct packed {
    logic [7:0]               lint;
    logic [NUM_CH-1:0][7:0]   chan;
  } snap_t;

endpackage

// File: rtl/duty_scaler_seq_if.sv
// Signal bundle between duty_scaler_seq and its environment (stimulus,
// shared 8x8 multiplier, PWM duty consumers).
//   slave  : the scaler itself
//   master : whoever drives requests and owns the multiplier
interface duty_scaler_seq_if;
  import duty_scaler_seq_pkg::*;

  logic        start;
  logic [7:0]  lint;
  logic [7:0]  red_in;
  logic [7:0]  green_in;
  logic [7:0]  blue_in;
  logic [7:0]  white_in;

  logic [7:0]  mult_a;
  logic [7:0]  mult_b;
  logic        mult_ld;
  logic        mult_rdy;
  logic [15:0] mult_res;

  logic [7:0]  red_duty;
  logic [7:0]  green_duty;
  logic [7:0]  blue_duty;
  logic [7:0]  white_duty;

  logic        busy;
  logic        done;
  logic        err;

  modport slave (
    input  start, lint, red_in, green_in, blue_in, white_in,
    input  mult_rdy, mult_res,
    output mult_a, mult_b, mult_ld,
    output red_duty, green_duty, blue_duty, white_duty,
    output busy, done, err
  );

  modport master (
    output start, lint, red_in, green_in, blue_in, white_in,
    output mult_rdy, mult_res,
    input  mult_a, mult_b, mult_ld,
    input  red_duty, green_duty, blue_duty, white_duty,
    input  busy, done, err
  );

endinterface

// File: rtl/duty_scaler_seq.sv
// duty_scaler_seq: rescales four colour channels by an intensity value using
// a shared external 8x8 multiplier, then updates all four PWM duties at once.
//
// Optional feature macro: FULLSCALE_BYPASS_EN
//   When defined, a snapshot intensity of 255 passes channel values straight
//   to the duties without touching the multiplier.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | present operands and strobe mult_ld for one cycle
// WAIT  | waiting for mult_rdy, bounded by MULT_TIMEOUT cycles
// STORE | advance to next channel or finish
// DONE  | publish shadow values to duties, pulse done
module duty_scaler_seq
  import duty_scaler_seq_pkg::*;
#(
  parameter int MULT_TIMEOUT = 63
) (
  input  logic               clk,
  input  logic               reset,
  duty_scaler_seq_if.slave   bus
);

  localparam int TW = (MULT_TIMEOUT > 1) ? $clog2(MULT_TIMEOUT) : 1;

  state_t                  state_q, state_d;
  logic [1:0]              ch_q, ch_d;
  logic                    pending_q, pending_d;
  logic                    err_q, err_d;
  snap_t                   snap_q, snap_d;
  logic [NUM_CH-1:0][7:0]  shadow_q, shadow_d;
  logic [NUM_CH-1:0][7:0]  duty_q, duty_d;
  logic [TW-1:0]           tmo_q, tmo_d;

  snap_t                   live_snap;
  logic                    full_scale;
  logic                    res_lo_unused;

  // Only the high byte of the product is used as the scaled duty
  assign res_lo_unused = ^bus.mult_res[7:0];

  // Current input values in snapshot form
  always_comb begin
    live_snap                = '0;
    live_snap.lint           = bus.lint;
    live_snap.chan[CH_RED]   = bus.red_in;
    live_snap.chan[CH_GREEN] = bus.green_in;
    live_snap.chan[CH_BLUE]  = bus.blue_in;
    live_snap.chan[CH_WHITE] = bus.white_in;
  end

`ifdef FULLSCALE_BYPASS_EN
  // Full intensity needs no multiply; the duty equals the channel value
  assign full_scale = (snap_q.lint == 8'hFF);
`else
  assign full_scale = 1'b0;
`endif

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    pending_d = pending_q;
    err_d     = err_q;
    snap_d    = snap_q;
    shadow_d  = shadow_q;
    duty_d    = duty_q;
    tmo_d     = tmo_q;

    // Starts arriving mid-sequence coalesce into one rerun; DONE handles
    // its own start directly so the rerun follows without an idle cycle.
    if (bus.start && (state_q != S_IDLE) && (state_q != S_DONE)) begin
      pending_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          snap_d    = live_snap;
          ch_d      = CH_RED;
          err_d     = 1'b0;
          pending_d = 1'b0;
          state_d   = S_LOAD;
        end
      end

      S_LOAD: begin
        if (full_scale) begin
          shadow_d[ch_q] = snap_q.chan[ch_q];
          state_d        = S_STORE;
        end else begin
          tmo_d   = TW'(MULT_TIMEOUT - 1);
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (bus.mult_rdy) begin
          shadow_d[ch_q] = bus.mult_res[15:8];
          state_d        = S_STORE;
        end else if (tmo_q == '0) begin
          // Abandon the whole sequence; duties keep their previous values
          err_d     = 1'b1;
          shadow_d  = '0;
          pending_d = 1'b0;
          state_d   = S_IDLE;
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
      end

      S_STORE: begin
        if (ch_q == CH_WHITE) begin
          // Duties load on entry to DONE so they change together with done
          duty_d  = shadow_q;
          state_d = S_DONE;
        end else begin
          ch_d    = ch_q + 2'd1;
          state_d = S_LOAD;
        end
      end

      S_DONE: begin
        if (pending_q || bus.start) begin
          snap_d    = live_snap;
          ch_d      = CH_RED;
          pending_d = 1'b0;
          state_d   = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ch_q      <= CH_RED;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
      snap_q    <= '0;
      shadow_q  <= '0;
      duty_q    <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      pending_q <= pending_d;
      err_q     <= err_d;
      snap_q    <= snap_d;
      shadow_q  <= shadow_d;
      duty_q    <= duty_d;
      tmo_q     <= tmo_d;
    end
  end

  // Operands come straight from the snapshot, so they cannot move while
  // the multiplier is working on the current channel.
  assign bus.mult_a     = snap_q.chan[ch_q];
  assign bus.mult_b     = snap_q.lint;
  assign bus.mult_ld    = (state_q == S_LOAD) && !full_scale;

  assign bus.red_duty   = duty_q[CH_RED];
  assign bus.green_duty = duty_q[CH_GREEN];
  assign bus.blue_duty  = duty_q[CH_BLUE];
  assign bus.white_duty = duty_q[CH_WHITE];

  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.err        = err_q;

endmodule

// File: tb/tb_duty_scaler_seq.sv
// Directed bench for duty_scaler_seq with a latency-L multiplier model.
module tb_duty_scaler_seq;

  logic clk;
  logic reset;
  duty_scaler_seq_if bus ();

  duty_scaler_seq #(.MULT_TIMEOUT(63)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Multiplier model: mult_rdy pulses L cycles after the cycle with mult_ld
  int          lat = 3;
  bit          model_en = 1'b1;
  int          mcnt = 0;
  logic [15:0] pend_prod = '0;
  logic        rdy_model = 1'b0;
  logic        rdy_stray = 1'b0;
  logic [15:0] res_model = '0;

  assign bus.mult_rdy = rdy_model | rdy_stray;
  assign bus.mult_res = res_model;

  always @(posedge clk) begin
    #1;
    rdy_model = 1'b0;
    if (mcnt > 0) begin
      mcnt = mcnt - 1;
      if (mcnt == 0) begin
        rdy_model = 1'b1;
        res_model = pend_prod;
      end
    end
    if (model_en && bus.mult_ld) begin
      mcnt      = lat;
      pend_prod = 16'(bus.mult_a) * 16'(bus.mult_b);
    end
  end

  // Observations collected by run_seq
  logic [7:0] seen_a [4];
  logic [7:0] seen_b [4];
  int chg_r, chg_g, chg_b, chg_w;
  logic err_c1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inputs(input logic [7:0] l, input logic [7:0] r,
                            input logic [7:0] g, input logic [7:0] b,
                            input logic [7:0] w);
    bus.lint     = l;
    bus.red_in   = r;
    bus.green_in = g;
    bus.blue_in  = b;
    bus.white_in = w;
  endtask

  // Called in the cycle where start is high (cycle 0); runs until done
  // or the cycle budget expires (done_cyc = -1).
  task automatic run_seq(input int max_cyc, input int stray_at,
                         output int done_cyc, output int ld_cnt);
    logic [7:0] r0, g0, b0, w0;
    r0 = bus.red_duty; g0 = bus.green_duty;
    b0 = bus.blue_duty; w0 = bus.white_duty;
    chg_r = -1; chg_g = -1; chg_b = -1; chg_w = -1;
    done_cyc = -1;
    ld_cnt = 0;
    for (int n = 1; n <= max_cyc; n++) begin
      tick();
      bus.start = 1'b0;
      rdy_stray = (n == stray_at);
      if (n == 1) err_c1 = bus.err;
      if (bus.mult_ld) begin
        if (ld_cnt < 4) begin
          seen_a[ld_cnt] = bus.mult_a;
          seen_b[ld_cnt] = bus.mult_b;
        end
        ld_cnt++;
      end
      if (chg_r < 0 && bus.red_duty   !== r0) chg_r = n;
      if (chg_g < 0 && bus.green_duty !== g0) chg_g = n;
      if (chg_b < 0 && bus.blue_duty  !== b0) chg_b = n;
      if (chg_w < 0 && bus.white_duty !== w0) chg_w = n;
      if (bus.done) begin
        done_cyc = n;
        break;
      end
    end
    rdy_stray = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0;
    set_inputs(8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    repeat (3) tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0 || bus.mult_ld !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: busy=%b done=%b err=%b mult_ld=%b expected all 0",
               bus.busy, bus.done, bus.err, bus.mult_ld);
    end
    checks++;
    if ({bus.red_duty, bus.green_duty, bus.blue_duty, bus.white_duty} !== 32'h0 ||
        bus.mult_a !== 8'd0 || bus.mult_b !== 8'd0) begin
      failures++;
      $display("FAIL reset_data: duties=%h mult_a=%0d mult_b=%0d expected 0",
               {bus.red_duty, bus.green_duty, bus.blue_duty, bus.white_duty}, bus.mult_a, bus.mult_b);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int dc, lc;
    set_inputs(8'd128, 8'd200, 8'd100, 8'd255, 8'd0);
    bus.start = 1'b1;
    fork
      begin
        tick();
        tick();
        // Inputs changing mid-sequence must not leak into this run
        set_inputs(8'd3, 8'd1, 8'd2, 8'd3, 8'd4);
      end
    join_none
    run_seq(100, -1, dc, lc);
    checks++;
    if (dc !== 21) begin
      failures++;
      $display("FAIL basic_latency: done at cycle %0d expected 21", dc);
    end
    checks++;
    if ({bus.red_duty, bus.green_duty, bus.blue_duty, bus.white_duty} !==
        {8'd100, 8'd50, 8'd127, 8'd0}) begin
      failures++;
      $display("FAIL basic_duties: got %0d/%0d/%0d/%0d expected 100/50/127/0",
               bus.red_duty, bus.green_duty, bus.blue_duty, bus.white_duty);
    end
    checks++;
    if (chg_r !== 21 || chg_g !== 21 || chg_b !== 21) begin
      failures++;
      $display("FAIL basic_atomic: change cycles r=%0d g=%0d b=%0d expected 21",
               chg_r, chg_g, chg_b);
    end
    checks++;
    if (lc !== 4 || seen_a[0] !== 8'd200 || seen_a[1] !== 8'd100 || seen_a[2] !== 8'd255 ||
        seen_a[3] !== 8'd0 || seen_b[0] !== 8'd128 || seen_b[3] !== 8'd128) begin
      failures++;
      $display("FAIL basic_operands: loads=%0d a=%0d,%0d,%0d,%0d b0=%0d b3=%0d expected 4 200,100,255,0 128 128",
               lc, seen_a[0], seen_a[1], seen_a[2], seen_a[3], seen_b[0], seen_b[3]);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_after: done=%b busy=%b expected 0 0", bus.done, bus.busy);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int d1, d2, ndone;
    logic busy22, busy_end;
    logic [31:0] duty1, duty2;
    d1 = -1; d2 = -1; ndone = 0; busy22 = 1'b0; busy_end = 1'b1;
    duty1 = '0; duty2 = '0;
    set_inputs(8'd64, 8'd40, 8'd80, 8'd120, 8'd160);
    bus.start = 1'b1;
    for (int n = 1; n <= 120; n++) begin
      tick();
      bus.start = (n == 3) || (n == 7) || (n == 12);
      if (n == 15) set_inputs(8'd200, 8'd10, 8'd100, 8'd250, 8'd255);
      if (n == 22) busy22 = bus.busy;
      if (bus.done) begin
        ndone++;
        if (d1 < 0) begin
          d1 = n;
          duty1 = {bus.red_duty, bus.green_duty, bus.blue_duty, bus.white_duty};
        end else if (d2 < 0) begin
          d2 = n;
          duty2 = {bus.red_duty, bus.green_duty, bus.blue_duty, bus.white_duty};
        end
      end
      if (n == 120) busy_end = bus.busy;
    end
    checks++;
    if (d1 !== 21 || d2 !== 42 || ndone !== 2) begin
      failures++;
      $display("FAIL b2b_done: first=%0d second=%0d count=%0d expected 21 42 2", d1, d2, ndone);
    end
    checks++;
    if (busy22 !== 1'b1 || busy_end !== 1'b0) begin
      failures++;
      $display("FAIL b2b_busy: busy@22=%b busy@end=%b expected 1 0", busy22, busy_end);
    end
    checks++;
    if (duty1 !== {8'd10, 8'd20, 8'd30, 8'd40}) begin
      failures++;
      $display("FAIL b2b_first_duties: got %h expected 0a141e28", duty1);
    end
    checks++;
    if (duty2 !== {8'd7, 8'd78, 8'd195, 8'd199}) begin
      failures++;
      $display("FAIL b2b_second_duties: got %h expected 074ec3c7", duty2);
    end
  endtask

  task automatic test_timeout();
    int err_at, ldc, dc, lc;
    logic saw_done, busy64;
    err_at = -1; ldc = 0; saw_done = 1'b0; busy64 = 1'b0;
    model_en = 1'b0;
    set_inputs(8'd50, 8'd11, 8'd22, 8'd33, 8'd44);
    bus.start = 1'b1;
    for (int n = 1; n <= 80; n++) begin
      tick();
      bus.start = 1'b0;
      if (bus.mult_ld) ldc++;
      if (bus.done) saw_done = 1'b1;
      if (n == 64) busy64 = bus.busy;
      if (err_at < 0 && bus.err === 1'b1) err_at = n;
    end
    checks++;
    if (err_at !== 65 || busy64 !== 1'b1) begin
      failures++;
      $display("FAIL timeout_err: err first at cycle %0d busy@64=%b expected 65 1", err_at, busy64);
    end
    checks++;
    if (saw_done !== 1'b0 || ldc !== 1 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_flow: done_seen=%b loads=%0d busy=%b expected 0 1 0", saw_done, ldc, bus.busy);
    end
    checks++;
    if ({bus.red_duty, bus.green_duty, bus.blue_duty, bus.white_duty} !==
        {8'd7, 8'd78, 8'd195, 8'd199}) begin
      failures++;
      $display("FAIL timeout_duties: got %0d/%0d/%0d/%0d expected 7/78/195/199",
               bus.red_duty, bus.green_duty, bus.blue_duty, bus.white_duty);
    end
    model_en = 1'b1;
    set_inputs(8'd128, 8'd2, 8'd4, 8'd6, 8'd8);
    bus.start = 1'b1;
    run_seq(100, -1, dc, lc);
    checks++;
    if (err_c1 !== 1'b0 || bus.err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_clear: err@1=%b err@done=%b expected 0 0", err_c1, bus.err);
    end
    checks++;
    if (dc !== 21 || {bus.red_duty, bus.green_duty, bus.blue_duty, bus.white_duty} !==
        {8'd1, 8'd2, 8'd3, 8'd4}) begin
      failures++;
      $display("FAIL timeout_recover: done=%0d duties=%h expected 21 01020304",
               dc, {bus.red_duty, bus.green_duty, bus.blue_duty, bus.white_duty});
    end
    tick();
  endtask

  task automatic test_stray_rdy();
    int dc, lc;
    rdy_stray = 1'b1;
    tick();
    rdy_stray = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL stray_idle: busy=%b done=%b expected 0 0", bus.busy, bus.done);
    end
    tick();
    set_inputs(8'd100, 8'd50, 8'd150, 8'd250, 8'd10);
    bus.start = 1'b1;
    run_seq(100, 1, dc, lc);
    checks++;
    if (dc !== 21 || {bus.red_duty, bus.green_duty, bus.blue_duty, bus.white_duty} !==
        {8'd19, 8'd58, 8'd97, 8'd3}) begin
      failures++;
      $display("FAIL stray_load: done=%0d duties=%0d/%0d/%0d/%0d expected 21 19/58/97/3",
               dc, bus.red_duty, bus.green_duty, bus.blue_duty, bus.white_duty);
    end
    tick();
  endtask

  task automatic test_fullscale();
    int dc, lc;
    int exp_dc, exp_lc;
    logic [31:0] exp_duty;
`ifdef FULLSCALE_BYPASS_EN
    exp_dc = 9;  exp_lc = 0; exp_duty = {8'd255, 8'd0, 8'd128, 8'd1};
`else
    exp_dc = 21; exp_lc = 4; exp_duty = {8'd254, 8'd0, 8'd127, 8'd0};
`endif
    set_inputs(8'd255, 8'd255, 8'd0, 8'd128, 8'd1);
    bus.start = 1'b1;
    run_seq(100, -1, dc, lc);
    checks++;
    if (dc !== exp_dc || lc !== exp_lc) begin
      failures++;
      $display("FAIL fullscale_timing: done=%0d loads=%0d expected %0d %0d", dc, lc, exp_dc, exp_lc);
    end
    checks++;
    if ({bus.red_duty, bus.green_duty, bus.blue_duty, bus.white_duty} !== exp_duty) begin
      failures++;
      $display("FAIL fullscale_duties: got %h expected %h",
               {bus.red_duty, bus.green_duty, bus.blue_duty, bus.white_duty}, exp_duty);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    set_inputs(8'd90, 8'd70, 8'd60, 8'd50, 8'd40);
    bus.start = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      bus.start = 1'b0;
    end
    reset = 1'b1;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.mult_ld !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
      failures++;
      $display("FAIL midreset_flags: busy=%b mult_ld=%b done=%b err=%b expected 0",
               bus.busy, bus.mult_ld, bus.done, bus.err);
    end
    checks++;
    if ({bus.red_duty, bus.green_duty, bus.blue_duty, bus.white_duty} !== 32'h0 ||
        bus.mult_a !== 8'd0 || bus.mult_b !== 8'd0) begin
      failures++;
      $display("FAIL midreset_data: duties=%h mult_a=%0d mult_b=%0d expected 0",
               {bus.red_duty, bus.green_duty, bus.blue_duty, bus.white_duty}, bus.mult_a, bus.mult_b);
    end
    bus.start = 1'b1;
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_priority: busy=%b expected 0", bus.busy);
    end
    reset = 1'b0;
    bus.start = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: busy=%b expected 0", bus.busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_timeout();
    test_stray_rdy();
    test_fullscale();
    test_reset_mid();
    repeat (5) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
